// File: rtl/sin_gen_pkg.sv
// Shared types and elaboration-time helpers for the sine/cosine generator.
// The LUT contents are computed here from the sample width and table size so
// the table never has to be regenerated by hand when the parameters change.
package sin_gen_pkg;

  // Legal range for log2 of the table length.
  localparam int LUT_LOG2_MIN = 2;
  localparam int LUT_LOG2_MAX = 8;

  localparam real TWO_PI = 6.283185307179586;

  // Number of Taylor terms used for sin(x), x in [0, pi/2]. Twelve terms put
  // the truncation error far below half an LSB for any practical width.
  localparam int TAYLOR_TERMS = 12;

  // Sequencer states: idle, counting out the hold time, emitting a sample.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } gen_state_t;

  // Peak amplitude for a signed sample of the given width.
  function automatic int lut_amp(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  // Table entry k of an n = 2**lut_log2 entry sine period:
  // round(A * sin(2*pi*k/n)), rounding half away from zero.
  // The angle is folded into the first quadrant so the series only has to
  // converge on [0, pi/2]; the exact points 0 and pi/2 then land precisely.
  function automatic int lut_entry(input int out_w, input int lut_log2, input int k);
    int  n;
    int  quarter;
    int  quad;
    int  j;
    int  mag;
    real x;
    real term;
    real acc;
    n       = 1 << lut_log2;
    quarter = n / 4;
    quad    = (k / quarter) % 4;
    j       = k % quarter;
    // Second and fourth quadrants mirror about pi/2.
    if (quad == 1 || quad == 3) begin
      j = quarter - j;
    end
    x    = TWO_PI * $itor(j) / $itor(n);
    term = x;
    acc  = x;
    for (int i = 1; i < TAYLOR_TERMS; i++) begin
      term = -term * x * x / $itor((2 * i) * (2 * i + 1));
      acc  = acc + term;
    end
    mag = $rtoi($itor(lut_amp(out_w)) * acc + 0.5);
    // Third and fourth quadrants are the negative half-wave.
    if (quad >= 2) begin
      return -mag;
    end
    return mag;
  endfunction

endpackage

// File: rtl/sin_lut.sv
// Dual-read-port sine table. Contents are fixed at elaboration from the
// package helper; both reads are purely combinational so the caller decides
// where the register stage sits.
module sin_lut
  import sin_gen_pkg::*;
#(
  parameter int OUT_W    = 4,
  parameter int LUT_LOG2 = 2
) (
  input  logic        [LUT_LOG2-1:0] addr_a,
  input  logic        [LUT_LOG2-1:0] addr_b,
  output logic signed [OUT_W-1:0]    data_a,
  output logic signed [OUT_W-1:0]    data_b
);

  localparam int N = 1 << LUT_LOG2;

  logic signed [OUT_W-1:0] lut_rom [N];

  // One constant per entry, evaluated at elaboration time.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rom
      localparam int ENTRY = lut_entry(OUT_W, LUT_LOG2, gi);
      assign lut_rom[gi] = OUT_W'(ENTRY);
    end
  endgenerate

  // Two independent asynchronous read ports.
  assign data_a = lut_rom[addr_a];
  assign data_b = lut_rom[addr_b];

endmodule

// File: rtl/sin_cos_gen.sv
// Quadrature sine/cosine sample generator. A small sequencer waits
// i_hold+1 cycles, then spends one cycle emitting a registered sine/cosine
// pair from a shared table, advancing the phase by i_step each sample.
module sin_cos_gen
  import sin_gen_pkg::*;
#(
  parameter int OUT_W    = 4,
  parameter int LUT_LOG2 = 2,
  parameter int HOLD_W   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_sync,
  input  logic        [HOLD_W-1:0]   i_hold,
  input  logic        [LUT_LOG2-1:0] i_step,
  output logic signed [OUT_W-1:0]    o_sin,
  output logic signed [OUT_W-1:0]    o_cos,
  output logic                       o_valid,
  output logic                       o_wrap
);

  localparam int N = 1 << LUT_LOG2;
  // A quarter period ahead in the sine table is the cosine.
  localparam logic [LUT_LOG2-1:0] QUARTER = LUT_LOG2'(N / 4);

  gen_state_t              state_reg;
  logic [HOLD_W-1:0]       cnt_reg;
  logic [LUT_LOG2-1:0]     phase_reg;

  logic [LUT_LOG2-1:0]     cos_addr_next;
  logic [LUT_LOG2:0]       phase_sum_next;
  logic signed [OUT_W-1:0] lut_sin_data;
  logic signed [OUT_W-1:0] lut_cos_data;

  // Cosine address wraps naturally in LUT_LOG2 bits; the extra sum bit is
  // the accumulator carry that flags a completed period.
  assign cos_addr_next  = phase_reg + QUARTER;
  assign phase_sum_next = {1'b0, phase_reg} + {1'b0, i_step};

  sin_lut #(
    .OUT_W    (OUT_W),
    .LUT_LOG2 (LUT_LOG2)
  ) u_lut (
    .addr_a (phase_reg),
    .addr_b (cos_addr_next),
    .data_a (lut_sin_data),
    .data_b (lut_cos_data)
  );

  // Sequencer, phase accumulator and registered outputs in one process.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      phase_reg <= '0;
      o_sin     <= '0;
      o_cos     <= '0;
      o_valid   <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
      if (i_sync) begin
        // Restart wins over a pending sample: nothing is emitted this cycle.
        phase_reg <= '0;
        cnt_reg   <= '0;
        state_reg <= i_en ? WAIT : IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            cnt_reg <= '0;
            if (i_en) begin
              state_reg <= WAIT;
            end
          end
          WAIT: begin
            if (!i_en) begin
              // Pause keeps the phase so a later enable resumes in sequence.
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end else if (cnt_reg >= i_hold) begin
              // >= so a hold value lowered mid-count still releases the FSM.
              state_reg <= SHIFT;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          SHIFT: begin
            o_sin     <= lut_sin_data;
            o_cos     <= lut_cos_data;
            o_valid   <= 1'b1;
            o_wrap    <= phase_sum_next[LUT_LOG2];
            phase_reg <= phase_sum_next[LUT_LOG2-1:0];
            cnt_reg   <= '0;
            state_reg <= i_en ? WAIT : IDLE;
          end
          default: begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sin_cos_gen.sv
// Self-checking bench for sin_cos_gen: a default 4-bit/4-entry instance and
// an 8-bit/16-entry instance share control inputs and are both compared each
// cycle against a behavioural model, plus directed sequence checks.
module tb_sin_cos_gen;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              sync;
  logic [2:0]        hold;
  logic [1:0]        step0;
  logic [3:0]        step8;
  logic signed [3:0] sin0, cos0;
  logic              valid0, wrap0;
  logic signed [7:0] sin8, cos8;
  logic              valid8, wrap8;

  int total = 0;
  int bad   = 0;
  int edge_no = 0;

  // Model state per instance: 0 = default instance, 1 = wide instance.
  int NN[2] = '{4, 16};
  int AA[2] = '{7, 127};
  int m_run[2], m_shift[2], m_pos[2], m_ph[2];
  int m_sin[2], m_cos[2], m_v[2], m_w[2];

  int q_edge0[$], q_sin0[$], q_cos0[$], q_wrap0[$], q_sin8[$];

  always #5 clk = ~clk;

  sin_cos_gen dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_sync  (sync),
    .i_hold  (hold),
    .i_step  (step0),
    .o_sin   (sin0),
    .o_cos   (cos0),
    .o_valid (valid0),
    .o_wrap  (wrap0)
  );

  sin_cos_gen #(.OUT_W(8), .LUT_LOG2(4), .HOLD_W(3)) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_sync  (sync),
    .i_hold  (hold),
    .i_step  (step8),
    .o_sin   (sin8),
    .o_cos   (cos8),
    .o_valid (valid8),
    .o_wrap  (wrap8)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Ideal rounded sine sample straight from the math library.
  function automatic int ref_lut(input int a, input int n, input int k);
    real r;
    r = $itor(a) * $sin(6.283185307179586 * $itor(k) / $itor(n));
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // One clock edge of the reference behaviour for instance i.
  task automatic ref_edge(input int i, input int stp);
    int n;
    n = NN[i];
    if (!rst_n) begin
      m_run[i] = 0; m_shift[i] = 0; m_pos[i] = 0; m_ph[i] = 0;
      m_sin[i] = 0; m_cos[i] = 0; m_v[i] = 0; m_w[i] = 0;
    end else begin
      m_v[i] = 0;
      m_w[i] = 0;
      if (sync) begin
        m_ph[i] = 0; m_pos[i] = 0; m_shift[i] = 0; m_run[i] = int'(en);
      end else if (m_run[i] == 0) begin
        m_pos[i] = 0;
        if (en) begin
          m_run[i] = 1;
          m_shift[i] = 0;
        end
      end else if (m_shift[i] != 0) begin
        m_sin[i] = ref_lut(AA[i], n, m_ph[i]);
        m_cos[i] = ref_lut(AA[i], n, (m_ph[i] + n / 4) % n);
        m_w[i]   = (m_ph[i] + stp >= n) ? 1 : 0;
        m_ph[i]  = (m_ph[i] + stp) % n;
        m_v[i]   = 1;
        m_shift[i] = 0;
        m_pos[i] = 0;
        m_run[i] = int'(en);
      end else if (!en) begin
        m_run[i] = 0;
        m_pos[i] = 0;
      end else if (m_pos[i] >= int'(hold)) begin
        m_shift[i] = 1;
        m_pos[i] = 0;
      end else begin
        m_pos[i]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ref_edge(0, int'(step0));
    ref_edge(1, int'(step8));
    edge_no++;
    #1;
    chk("valid0", valid0, m_v[0]);
    chk("wrap0",  wrap0,  m_w[0]);
    chk("sin0",   sin0,   m_sin[0]);
    chk("cos0",   cos0,   m_cos[0]);
    chk("valid8", valid8, m_v[1]);
    chk("wrap8",  wrap8,  m_w[1]);
    chk("sin8",   sin8,   m_sin[1]);
    chk("cos8",   cos8,   m_cos[1]);
    if (valid0) begin
      q_edge0.push_back(edge_no);
      q_sin0.push_back(int'(sin0));
      q_cos0.push_back(int'(cos0));
      q_wrap0.push_back(int'(wrap0));
      $display("tx edge=%0d dut sin=%0d cos=%0d wrap=%0d", edge_no, sin0, cos0, wrap0);
    end
    if (valid8) begin
      q_sin8.push_back(int'(sin8));
      $display("tx edge=%0d dut8 sin=%0d cos=%0d wrap=%0d", edge_no, sin8, cos8, wrap8);
    end
  endtask

  task automatic clear_q();
    q_edge0.delete(); q_sin0.delete(); q_cos0.delete(); q_wrap0.delete(); q_sin8.delete();
  endtask

  int exp_sin_a[5]  = '{0, 7, 0, -7, 0};
  int exp_cos_a[5]  = '{7, 0, -7, 0, 7};
  int exp_wrap_a[5] = '{0, 0, 0, 1, 0};
  int exp_sin8[16]  = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};
  int exp_cos_b[4]  = '{7, -7, 7, -7};
  int exp_wrap_b[4] = '{0, 1, 0, 1};

  initial begin
    int base;
    int n;
    int vcount;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_shift[i] = 0; m_pos[i] = 0; m_ph[i] = 0;
      m_sin[i] = 0; m_cos[i] = 0; m_v[i] = 0; m_w[i] = 0;
    end
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; hold = 3'd3; step0 = 2'd1; step8 = 4'd1;

    // Reset state.
    repeat (3) tick();
    chk("rst_sin0", sin0, 0);
    chk("rst_valid0", valid0, 0);

    // Default sequence and wide-table sequence, step 1, hold 3.
    clear_q();
    rst_n = 1'b1; en = 1'b1;
    base = edge_no;
    repeat (85) tick();
    chk("a_count", (q_sin0.size() >= 5 && q_sin8.size() >= 16) ? 1 : 0, 1);
    if (q_sin0.size() >= 5) begin
      chk("a_first_edge", q_edge0[0] - base, 6);
      for (int k = 0; k < 4; k++) chk("a_gap", q_edge0[k+1] - q_edge0[k], 5);
      for (int k = 0; k < 5; k++) begin
        chk("a_sin", q_sin0[k], exp_sin_a[k]);
        chk("a_cos", q_cos0[k], exp_cos_a[k]);
        chk("a_wrap", q_wrap0[k], exp_wrap_a[k]);
      end
    end
    if (q_sin8.size() >= 16) begin
      for (int k = 0; k < 16; k++) chk("a_sin8", q_sin8[k], exp_sin8[k]);
    end

    // Step 2, hold 0: two-cycle period, wrap every second sample.
    rst_n = 1'b0;
    repeat (2) tick();
    clear_q();
    hold = 3'd0; step0 = 2'd2; step8 = 4'd2;
    rst_n = 1'b1; en = 1'b1;
    base = edge_no;
    repeat (12) tick();
    chk("b_count", (q_sin0.size() >= 4) ? 1 : 0, 1);
    if (q_sin0.size() >= 4) begin
      chk("b_first_edge", q_edge0[0] - base, 3);
      for (int k = 0; k < 4; k++) begin
        chk("b_sin", q_sin0[k], 0);
        chk("b_cos", q_cos0[k], exp_cos_b[k]);
        chk("b_wrap", q_wrap0[k], exp_wrap_b[k]);
      end
      chk("b_gap", q_edge0[1] - q_edge0[0], 2);
    end

    // Sync landing on the third sample's emitting cycle.
    rst_n = 1'b0;
    repeat (2) tick();
    clear_q();
    hold = 3'd3; step0 = 2'd1; step8 = 4'd1;
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 30 && q_sin0.size() < 2; i++) tick();
    chk("c_two_samples", (q_sin0.size() >= 2) ? 1 : 0, 1);
    repeat (4) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("c_sync_novalid", valid0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (valid0) break;
    end
    chk("c_sync_latency", n, 5);
    chk("c_sync_sin", sin0, 0);
    chk("c_sync_cos", cos0, 7);

    // Enable dropped mid-wait: outputs freeze, phase resumes afterwards.
    repeat (2) tick();
    en = 1'b0;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vcount += int'(valid0);
    end
    chk("d_no_valid", vcount, 0);
    chk("d_hold_cos", cos0, 7);
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (valid0) break;
    end
    chk("d_resume_latency", n, 6);
    chk("d_resume_sin", sin0, 7);
    chk("d_resume_cos", cos0, 0);

    // Reset in the middle of a wait on the wide instance.
    rst_n = 1'b0;
    repeat (2) tick();
    clear_q();
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 30 && q_sin8.size() < 2; i++) tick();
    chk("e_pre_cos8", cos8, 117);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("e_rst_sin8", sin8, 0);
    chk("e_rst_cos8", cos8, 0);
    chk("e_rst_valid8", valid8, 0);
    chk("e_rst_cos0", cos0, 0);
    rst_n = 1'b1;

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      sync  = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) hold = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        step0 = 2'($urandom_range(0, 3));
        step8 = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sin_cos_gen.md
SIN_COS_GEN -- requirements
Module: sin_cos_gen

Interface
REQ-001 The block SHALL have parameter OUT_W, default 4: signed sample width.
REQ-002 The block SHALL have parameter LUT_LOG2, default 2, legal range 2..8: log2 of entries per sine period (N = 2**LUT_LOG2).
REQ-003 The block SHALL have parameter HOLD_W, default 3: width of the hold-count input.
REQ-004 The block SHALL have port i_clk, input, 1 bit: sole clock, rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port i_en, input, 1 bit: run enable.
REQ-007 The block SHALL have port i_sync, input, 1 bit: single-cycle phase restart.
REQ-008 The block SHALL have port i_hold, input, HOLD_W bits: WAIT length minus one, in cycles.
REQ-009 The block SHALL have port i_step, input, LUT_LOG2 bits: phase increment per sample.
REQ-010 The block SHALL have port o_sin, output, OUT_W bits, signed: sine sample, registered.
REQ-011 The block SHALL have port o_cos, output, OUT_W bits, signed: cosine sample, registered.
REQ-012 The block SHALL have port o_valid, output, 1 bit: one-cycle pulse marking new o_sin/o_cos.
REQ-013 The block SHALL have port o_wrap, output, 1 bit: one-cycle pulse, coincident with o_valid, when the phase accumulator overflows.

Function
REQ-014 The LUT SHALL hold N entries, with entry k = round(A*sin(2*pi*k/N)) and A = 2**(OUT_W-1)-1; defaults give 0, 7, 0, -7.
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and SHIFT.
REQ-016 In IDLE: if i_en=1, the FSM SHALL go to WAIT next edge with counter=0; otherwise it SHALL stay in IDLE.
REQ-017 In WAIT, the counter SHALL increment each cycle, and when counter >= i_hold the FSM SHALL go to SHIFT next edge.
REQ-018 The >= compare SHALL be used so that lowering i_hold mid-WAIT never stalls the FSM.
REQ-019 The counter SHALL clear on every cycle outside WAIT.
REQ-020 In SHIFT, at the exiting edge: o_sin <= LUT[phase]; o_cos <= LUT[(phase + N/4) mod N]; phase <= (phase + i_step) mod N; o_valid <= 1.
REQ-021 In that same SHIFT cycle, o_wrap SHALL be set to 1 if and only if phase + i_step >= N.
REQ-022 From SHIFT, the FSM SHALL go to WAIT if i_en=1, else to IDLE.
REQ-023 The sample period SHALL be i_hold+2 cycles; o_valid SHALL be high for exactly 1 cycle per period.
REQ-024 First-sample latency SHALL be i_hold+3 edges from the first edge at which i_en=1 is sampled in IDLE.
REQ-025 o_sin and o_cos SHALL hold their values between o_valid pulses and while in IDLE.
REQ-026 i_en low in WAIT SHALL send the FSM to IDLE next edge, with phase retained; outputs SHALL hold.
REQ-027 On i_sync=1, phase and counter SHALL go to 0 next edge, and the FSM SHALL go to WAIT (i_en=1) or IDLE (i_en=0).
REQ-028 i_sync SHALL have priority over SHIFT: in that cycle no output update, o_valid=0 and o_wrap=0.
REQ-029 With i_step=0, outputs SHALL repeat the same sample at every o_valid.
REQ-030 i_step SHALL be sampled only in SHIFT.

Reset
REQ-031 While i_rst_n=0 at an edge: state=IDLE, counter=0, phase=0, o_sin=0, o_cos=0, o_valid=0, o_wrap=0.
REQ-032 Reset SHALL take effect mid-operation, in any state, on the next edge, and SHALL override i_sync and i_en.

Structure
REQ-033 Package sin_gen_pkg SHALL hold the state enum typedef and a constant function that builds the LUT from OUT_W and LUT_LOG2.
REQ-034 A combinational sub-module sin_lut SHALL provide two read ports (addr_a, addr_b), instantiated once for the sine and cosine reads.
REQ-035 No latches SHALL be inferred; all outputs SHALL be driven from always_ff.

Verification
REQ-036 Defaults, i_hold=3, i_step=1, i_en=1 after reset -> first o_valid at edge 6; o_sin sequence 0, 7, 0, -7, 0; o_cos sequence 7, 0, -7, 0, 7; pulses 5 cycles apart; o_wrap with the 4th sample.
REQ-037 i_step=2, i_hold=0 -> o_sin 0, 0, ...; o_cos 7, -7, 7, ...; period 2 cycles; o_wrap on every 2nd sample.
REQ-038 i_sync asserted in the SHIFT cycle of sample 3 -> no pulse that cycle; next sample is o_sin=0, o_cos=7 after i_hold+2 cycles.
REQ-039 i_en dropped in WAIT for 10 cycles, then raised -> outputs frozen, no o_valid; sequence resumes at the retained phase.
REQ-040 OUT_W=8, LUT_LOG2=4 -> o_sin over 16 samples is 0, 49, 90, 117, 127, 117, 90, 49, 0, -49, ...; reset asserted mid-WAIT -> all outputs 0 next edge.
